// File: rtl/issue_rs_wakeup_pkg.sv
// Shared defaults for the issue reservation station and its age-matrix select.
package issue_rs_wakeup_pkg;
    localparam int RS_P_DEPTH   = 3;
    localparam int RS_PRF_AW    = 6;
    localparam int RS_PAYLOAD_W = 64;
    localparam int RS_NUM_WB    = 2;
endpackage

// File: rtl/rs_age_matrix.sv
// Relative-age matrix for the RS entries; picks the oldest ready candidate as a one-hot.
module rs_age_matrix
    import issue_rs_wakeup_pkg::*;
#(
    parameter int DEPTH = 1 << RS_P_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DEPTH-1:0] push_oh,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] cand,
    output logic [DEPTH-1:0] sel
);
    // age[i][j] = 1 means entry i is older than entry j
    logic [DEPTH-1:0][DEPTH-1:0] age;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            age <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                for (int j = 0; j < DEPTH; j++)
                    if (push_oh[i])      age[i][j] <= 1'b0;
                    else if (push_oh[j]) age[i][j] <= valid[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_sel
        logic [DEPTH-1:0] older;
        for (genvar j = 0; j < DEPTH; j++) begin : g_col
            assign older[j] = age[j][i];
        end
        assign sel[i] = cand[i] & ~|(cand & older);
    end
endmodule

// File: rtl/issue_rs_wakeup.sv
// Out-of-order reservation station: wakeup tracking, oldest-ready select, registered issue stage.
module issue_rs_wakeup
    import issue_rs_wakeup_pkg::*;
#(
    parameter int P_DEPTH   = RS_P_DEPTH,
    parameter int PRF_AW    = RS_PRF_AW,
    parameter int PAYLOAD_W = RS_PAYLOAD_W,
    parameter int NUM_WB    = RS_NUM_WB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [PAYLOAD_W-1:0]     issue_payload,
    input  logic [PRF_AW-1:0]        issue_prs1,
    input  logic                     issue_prs1_re,
    input  logic                     issue_prs1_busy,
    input  logic [PRF_AW-1:0]        issue_prs2,
    input  logic                     issue_prs2_re,
    input  logic                     issue_prs2_busy,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PRF_AW-1:0] wb_prd,
    output logic                     ro_valid,
    input  logic                     ro_ready,
    output logic [PAYLOAD_W-1:0]     ro_payload,
    output logic [PRF_AW-1:0]        ro_prs1,
    output logic                     ro_prs1_re,
    output logic [PRF_AW-1:0]        ro_prs2,
    output logic                     ro_prs2_re,
    output logic [P_DEPTH:0]         rs_count
);
    localparam int DEPTH = 1 << P_DEPTH;
    localparam int CW    = P_DEPTH + 1;

    logic [DEPTH-1:0]                valid, rdy1, rdy2, re1, re2;
    logic [DEPTH-1:0][PRF_AW-1:0]    prs1, prs2;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] payload;
    logic [DEPTH-1:0]                free, push_oh, cand, sel, deq_oh;
    logic                            push, adv, deq, new_rdy1, new_rdy2;
    logic [P_DEPTH-1:0]              sel_idx;

    function automatic logic wb_hit(input logic [NUM_WB-1:0]        v,
                                    input logic [NUM_WB*PRF_AW-1:0] prd,
                                    input logic [PRF_AW-1:0]        r);
        logic h;
        h = 1'b0;
        for (int k = 0; k < NUM_WB; k++)
            h = h | (v[k] && (prd[k*PRF_AW +: PRF_AW] == r));
        return h;
    endfunction

    // Full check uses registered occupancy only, so a slot freed by this cycle's issue waits a cycle
    assign issue_ready = ~&valid;
    assign push        = issue_valid & issue_ready & ~flush;
    assign free        = ~valid;
    assign push_oh     = (free & (~free + DEPTH'(1))) & {DEPTH{push}};

    assign new_rdy1 = ~issue_prs1_re | ~issue_prs1_busy | wb_hit(wb_valid, wb_prd, issue_prs1);
    assign new_rdy2 = ~issue_prs2_re | ~issue_prs2_busy | wb_hit(wb_valid, wb_prd, issue_prs2);

    assign cand   = valid & rdy1 & rdy2;
    assign adv    = ~ro_valid | ro_ready;
    assign deq    = adv & |cand;
    assign deq_oh = sel & {DEPTH{deq}};

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sel[i]) sel_idx = P_DEPTH'(i);
    end

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .push_oh (push_oh),
        .valid   (valid),
        .cand    (cand),
        .sel     (sel)
    );

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid    <= '0;
            rs_count <= '0;
        end else begin
            valid    <= (valid & ~deq_oh) | push_oh;
            rs_count <= rs_count + CW'(push) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy1 <= '0;
            rdy2 <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_oh[i]) begin
                    rdy1[i] <= new_rdy1;
                    rdy2[i] <= new_rdy2;
                end else begin
                    rdy1[i] <= rdy1[i] | wb_hit(wb_valid, wb_prd, prs1[i]);
                    rdy2[i] <= rdy2[i] | wb_hit(wb_valid, wb_prd, prs2[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_oh[i]) begin
                payload[i] <= issue_payload;
                prs1[i]    <= issue_prs1;
                re1[i]     <= issue_prs1_re;
                prs2[i]    <= issue_prs2;
                re2[i]     <= issue_prs2_re;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) ro_valid <= 1'b0;
        else if (adv)      ro_valid <= |cand;
    end

    always_ff @(posedge clk) begin
        if (deq) begin
            ro_payload <= payload[sel_idx];
            ro_prs1    <= prs1[sel_idx];
            ro_prs1_re <= re1[sel_idx];
            ro_prs2    <= prs2[sel_idx];
            ro_prs2_re <= re2[sel_idx];
        end
    end
endmodule

// File: tb/tb_issue_rs_wakeup.sv
// Bench for issue_rs_wakeup: wakeup vector table, issue-order scoreboard, stall/flush/reset sequences.
module tb_issue_rs_wakeup;
    localparam int P_DEPTH   = 3;
    localparam int PRF_AW    = 6;
    localparam int PAYLOAD_W = 64;
    localparam int NUM_WB    = 2;

    logic                     clk, rst, flush;
    logic                     issue_valid, issue_ready;
    logic [PAYLOAD_W-1:0]     issue_payload;
    logic [PRF_AW-1:0]        issue_prs1, issue_prs2;
    logic                     issue_prs1_re, issue_prs1_busy, issue_prs2_re, issue_prs2_busy;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*PRF_AW-1:0] wb_prd;
    logic                     ro_valid, ro_ready;
    logic [PAYLOAD_W-1:0]     ro_payload;
    logic [PRF_AW-1:0]        ro_prs1, ro_prs2;
    logic                     ro_prs1_re, ro_prs2_re;
    logic [P_DEPTH:0]         rs_count;

    issue_rs_wakeup #(.P_DEPTH(P_DEPTH), .PRF_AW(PRF_AW), .PAYLOAD_W(PAYLOAD_W), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_payload(issue_payload),
        .issue_prs1(issue_prs1), .issue_prs1_re(issue_prs1_re), .issue_prs1_busy(issue_prs1_busy),
        .issue_prs2(issue_prs2), .issue_prs2_re(issue_prs2_re), .issue_prs2_busy(issue_prs2_busy),
        .wb_valid(wb_valid), .wb_prd(wb_prd),
        .ro_valid(ro_valid), .ro_ready(ro_ready), .ro_payload(ro_payload),
        .ro_prs1(ro_prs1), .ro_prs1_re(ro_prs1_re), .ro_prs2(ro_prs2), .ro_prs2_re(ro_prs2_re),
        .rs_count(rs_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] p1; logic r1; logic b1;
        logic [5:0] p2; logic r2; logic b2;
        logic [1:0] wbv; logic [5:0] wb0; logic [5:0] wb1;
        logic       exp;
    } vec_t;

    vec_t             tbl [12];
    logic [63:0]      sb [$];
    logic [63:0]      mon_exp;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard pops on every accepted handshake; occupancy/ready relation checked each cycle.
    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if (issue_ready !== (rs_count != 4'd8)) begin
                n_fail++;
                $display("FAIL ready_vs_count: issue_ready=%0b rs_count=%0d", issue_ready, rs_count);
            end
            if (ro_valid && ro_ready && !flush) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: got payload %0h, expected none", ro_payload);
                end else begin
                    mon_exp = sb.pop_front();
                    if (ro_payload !== mon_exp) begin
                        n_fail++;
                        $display("FAIL issue_order: got payload %0h, expected %0h", ro_payload, mon_exp);
                    end
                end
            end
        end
    end

    task automatic push_op(input logic [63:0] pl, input logic [5:0] p1, input logic r1, input logic b1,
                           input logic [5:0] p2, input logic r2, input logic b2, input bit exp);
        int n;
        n = 0;
        issue_valid = 1'b1; issue_payload = pl;
        issue_prs1 = p1; issue_prs1_re = r1; issue_prs1_busy = b1;
        issue_prs2 = p2; issue_prs2_re = r2; issue_prs2_busy = b2;
        while (!issue_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_wait", issue_ready, 1'b1);
        if (exp) sb.push_back(pl);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((ro_valid || rs_count != 0) && n < 100) begin
            tick();
            n++;
        end
        chk(name, {ro_valid, 4'(rs_count)}, 5'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_payload = '0;
        issue_prs1 = '0; issue_prs1_re = 1'b0; issue_prs1_busy = 1'b0;
        issue_prs2 = '0; issue_prs2_re = 1'b0; issue_prs2_busy = 1'b0;
        wb_valid = '0; wb_prd = '0; ro_ready = 1'b0;

        //            p1  r1 b1 p2  r2 b2 wbv    wb0  wb1 exp
        tbl[0]  = '{6'd3, 1'b0, 1'b0, 6'd4, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0, 1'b1};
        tbl[1]  = '{6'd3, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 2'b00, 6'd0, 6'd0, 1'b1};
        tbl[2]  = '{6'd3, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0, 1'b0};
        tbl[3]  = '{6'd3, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 2'b01, 6'd3, 6'd0, 1'b1};
        tbl[4]  = '{6'd3, 1'b0, 1'b0, 6'd9, 1'b1, 1'b1, 2'b10, 6'd0, 6'd9, 1'b1};
        tbl[5]  = '{6'd3, 1'b1, 1'b1, 6'd4, 1'b1, 1'b1, 2'b11, 6'd3, 6'd7, 1'b0};
        tbl[6]  = '{6'd3, 1'b1, 1'b1, 6'd4, 1'b1, 1'b1, 2'b11, 6'd3, 6'd4, 1'b1};
        tbl[7]  = '{6'd3, 1'b0, 1'b1, 6'd4, 1'b0, 1'b1, 2'b00, 6'd0, 6'd0, 1'b1};
        tbl[8]  = '{6'd3, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 2'b00, 6'd3, 6'd0, 1'b0};
        tbl[9]  = '{6'd0, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 2'b01, 6'd0, 6'd0, 1'b1};
        tbl[10] = '{6'd3, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 2'b11, 6'd3, 6'd3, 1'b1};
        tbl[11] = '{6'd3, 1'b1, 1'b1, 6'd4, 1'b1, 1'b1, 2'b11, 6'd4, 6'd3, 1'b1};

        repeat (2) tick();
        chk("reset_ro_valid", ro_valid, 1'b0);
        chk("reset_count", rs_count, 4'd0);
        chk("reset_issue_ready", issue_ready, 1'b1);
        rst = 1'b1;

        // Readiness table: push into an empty RS, expect issue exactly two cycles later or never
        ro_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wb_valid = tbl[i].wbv;
            wb_prd   = {tbl[i].wb1, tbl[i].wb0};
            push_op(64'hA00 + 64'(i), tbl[i].p1, tbl[i].r1, tbl[i].b1,
                    tbl[i].p2, tbl[i].r2, tbl[i].b2, tbl[i].exp);
            wb_valid = '0;
            chk($sformatf("vec%0d_t1_ro_valid", i), ro_valid, 1'b0);
            tick();
            chk($sformatf("vec%0d_t2_ro_valid", i), ro_valid, tbl[i].exp);
            chk($sformatf("vec%0d_t2_count", i), rs_count, tbl[i].exp ? 4'd0 : 4'd1);
            if (!tbl[i].exp) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end else begin
                tick();
            end
        end

        // In-order stream of ready ops
        for (int i = 0; i < 8; i++)
            push_op(64'h100 + 64'(i), 6'(i), 1'b1, 1'b0, 6'(i + 8), 1'b1, 1'b0, 1'b1);
        wait_drain("t1_drain");
        chk("t1_sb_empty", sb.size(), 0);

        // Younger ready op bypasses older waiting op
        push_op(64'h2A, 6'd5, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        push_op(64'h2B, 6'd1, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b1);
        sb.push_back(64'h2A);
        chk("t2_idle", ro_valid, 1'b0);
        wb_valid = 2'b01; wb_prd = {6'd0, 6'd5};
        tick();
        wb_valid = '0;
        chk("t2_b_valid", ro_valid, 1'b1);
        chk("t2_b_payload", ro_payload, 64'h2B);
        tick();
        chk("t2_a_valid", ro_valid, 1'b1);
        chk("t2_a_payload", ro_payload, 64'h2A);
        chk("t2_a_prs1", ro_prs1, 6'd5);
        chk("t2_a_prs1_re", ro_prs1_re, 1'b1);
        tick();
        chk("t2_done", ro_valid, 1'b0);

        // Back-pressure with a full RS
        ro_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            push_op(64'h400 + 64'(i), 6'd1, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 1'b1);
        chk("t4_full_count", rs_count, 4'd8);
        chk("t4_full_ready", issue_ready, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", ro_valid, 1'b1);
            chk("t4_hold_payload", ro_payload, 64'h400);
            chk("t4_hold_ready", issue_ready, 1'b0);
            tick();
        end
        ro_ready = 1'b1;
        tick();
        chk("t4_release_ready", issue_ready, 1'b1);
        chk("t4_release_payload", ro_payload, 64'h401);
        chk("t4_release_count", rs_count, 4'd7);
        wait_drain("t4_drain");

        // Flush with a simultaneous push
        ro_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_op(64'h500 + 64'(i), 6'd1, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0);
        chk("t5_pre_count", rs_count, 4'd4);
        chk("t5_pre_valid", ro_valid, 1'b1);
        flush = 1'b1; issue_valid = 1'b1; issue_payload = 64'h5FF;
        issue_prs1_re = 1'b0; issue_prs2_re = 1'b0;
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        chk("t5_ro_valid", ro_valid, 1'b0);
        chk("t5_count", rs_count, 4'd0);
        chk("t5_issue_ready", issue_ready, 1'b1);
        ro_ready = 1'b1;
        repeat (4) tick();
        chk("t5_discarded", {ro_valid, 4'(rs_count)}, 5'd0);

        // Reset mid-stream
        ro_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_op(64'h600 + 64'(i), 6'd1, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_count", rs_count, 4'd3);
        rst = 1'b0;
        tick();
        chk("t6_ro_valid", ro_valid, 1'b0);
        chk("t6_count", rs_count, 4'd0);
        chk("t6_issue_ready", issue_ready, 1'b1);
        rst = 1'b1;
        ro_ready = 1'b1;
        repeat (4) tick();
        chk("t6_quiet", {ro_valid, 4'(rs_count)}, 5'd0);

        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
